// File: rtl/lo_pkg.sv
// Shared constants and helpers for the quadrature LO bank: period geometry,
// dead-zone clamping and the ternary (sign, non-zero) phase decode.
package lo_pkg;

  typedef struct packed {
    logic sgn;
    logic nz;
  } tern_t;

  function automatic int unsigned period_of(input int unsigned ph_w);
    return 32'd1 << ph_w;
  endfunction

  function automatic int unsigned half_of(input int unsigned ph_w);
    return 32'd1 << (ph_w - 1);
  endfunction

  function automatic int unsigned quarter_of(input int unsigned ph_w);
    return 32'd1 << (ph_w - 2);
  endfunction

  function automatic int unsigned dz_clamp(input int unsigned dz, input int unsigned ph_w);
    return (dz > quarter_of(ph_w)) ? quarter_of(ph_w) : dz;
  endfunction

  // Zero within dz samples either side of each half-period crossing.
  function automatic tern_t tern_decode(input int unsigned p, input int unsigned dz,
                                        input int unsigned ph_w);
    tern_t       t;
    int unsigned h;
    int unsigned d;
    int unsigned q;
    h     = half_of(ph_w);
    d     = dz_clamp(dz, ph_w);
    q     = p % h;
    t.sgn = 1'((p % period_of(ph_w)) >> (ph_w - 1));
    t.nz  = (q >= d) && (q + d <= h - 1);
    return t;
  endfunction

endpackage

// File: rtl/lo_bank_if.sv
// Config handshake and per-channel ternary LO outputs of the LO bank.
interface lo_bank_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DZ_W = 5
);
  logic            cfg_valid;
  logic [DZ_W-1:0] cfg_dz;
  logic            cfg_ready;
  logic [N_CH-1:0] sin_sgn;
  logic [N_CH-1:0] sin_nz;
  logic [N_CH-1:0] cos_sgn;
  logic [N_CH-1:0] cos_nz;
  logic [N_CH-1:0] wrap;

  modport master (
    output cfg_valid, cfg_dz,
    input  cfg_ready, sin_sgn, sin_nz, cos_sgn, cos_nz, wrap
  );

  modport slave (
    input  cfg_valid, cfg_dz,
    output cfg_ready, sin_sgn, sin_nz, cos_sgn, cos_nz, wrap
  );
endinterface

// File: rtl/lo_channel.sv
// One LO channel: phase counter, glitch-free dead-zone update at phase wrap,
// registered sin/cos ternary decode and wrap pulse.
module lo_channel
  import lo_pkg::*;
#(
  parameter int unsigned     PH_W   = 6,
  parameter int unsigned     DZ_W   = 5,
  parameter logic [DZ_W-1:0] DZ_RST = '0
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            tick_i,
  input  logic            phase_rst_i,
  input  logic            load_i,
  input  logic [DZ_W-1:0] shadow_i,
  output logic            pending_o,
  output logic            sin_sgn_o,
  output logic            sin_nz_o,
  output logic            cos_sgn_o,
  output logic            cos_nz_o,
  output logic            wrap_o
);

  localparam logic [PH_W-1:0] PH_MAX = '1;
  localparam logic [PH_W-1:0] PH_QTR = PH_W'(quarter_of(PH_W));

  logic [PH_W-1:0] ph_q, ph_d;
  logic [DZ_W-1:0] dz_q, dz_d;
  logic            pend_q, pend_d;
  tern_t           sin_q, sin_d, cos_q, cos_d;
  logic            wrap_q, wrap_d;
  logic            at_wrap;
  logic [PH_W-1:0] cos_ph;

  always_comb begin
    at_wrap = tick_i && (ph_q == PH_MAX);
    ph_d    = ph_q;
    dz_d    = dz_q;
    pend_d  = pend_q;
    if (phase_rst_i) begin
      ph_d   = '0;
      pend_d = 1'b0;
      if (load_i || pend_q) dz_d = shadow_i;
    end else begin
      if (tick_i) ph_d = ph_q + 1'b1;
      // A load coinciding with a wrap defers the update to the following wrap.
      if (load_i) begin
        pend_d = 1'b1;
      end else if (at_wrap && pend_q) begin
        dz_d   = shadow_i;
        pend_d = 1'b0;
      end
    end
    cos_ph = ph_q + PH_QTR;
    sin_d  = tern_decode(32'(ph_q), 32'(dz_q), PH_W);
    cos_d  = tern_decode(32'(cos_ph), 32'(dz_q), PH_W);
    wrap_d = at_wrap && !phase_rst_i;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      ph_q   <= '0;
      dz_q   <= DZ_RST;
      pend_q <= 1'b0;
      sin_q  <= '0;
      cos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      dz_q   <= dz_d;
      pend_q <= pend_d;
      sin_q  <= sin_d;
      cos_q  <= cos_d;
      wrap_q <= wrap_d;
    end
  end

  assign pending_o = pend_q;
  assign sin_sgn_o = sin_q.sgn;
  assign sin_nz_o  = sin_q.nz;
  assign cos_sgn_o = cos_q.sgn;
  assign cos_nz_o  = cos_q.nz;
  assign wrap_o    = wrap_q;

endmodule

// File: rtl/lo_bank.sv
// Multi-channel octave-spaced quadrature LO bank: shared prescaler, per-channel
// tick generation and a dead-zone config handshake fanned out to every channel.
module lo_bank
  import lo_pkg::*;
#(
  parameter int unsigned     N_CH   = 4,
  parameter int unsigned     PH_W   = 6,
  parameter int unsigned     DZ_W   = PH_W - 1,
  parameter logic [DZ_W-1:0] DZ_RST = '0
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       en,
  input  logic       phase_rst,
  lo_bank_if.slave   bus
);

  localparam int unsigned PRE_W = (N_CH > 1) ? N_CH - 1 : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DZ_W-1:0]  shadow_q, shadow_d;
  logic [DZ_W-1:0]  shadow_fwd;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  sin_sgn, sin_nz, cos_sgn, cos_nz, wrap;
  logic             xfer;

  assign bus.cfg_ready = ~|pending;
  assign xfer          = bus.cfg_valid && bus.cfg_ready;
  // Forwarding the incoming value lets phase_rst apply a same-cycle transfer.
  assign shadow_fwd    = xfer ? bus.cfg_dz : shadow_q;

  always_comb begin
    pre_d    = pre_q;
    shadow_d = shadow_q;
    if (phase_rst)   pre_d = '0;
    else if (en)     pre_d = pre_q + 1'b1;
    if (xfer)        shadow_d = bus.cfg_dz;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      pre_q    <= '0;
      shadow_q <= DZ_RST;
    end else begin
      pre_q    <= pre_d;
      shadow_q <= shadow_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    if (k == 0) begin : g_t0
      assign tick[k] = en;
    end else begin : g_tk
      assign tick[k] = en && (&pre_q[k-1:0]);
    end

    lo_channel #(
      .PH_W   (PH_W),
      .DZ_W   (DZ_W),
      .DZ_RST (DZ_RST)
    ) u_ch (
      .clk         (clk),
      .rstb        (rstb),
      .tick_i      (tick[k]),
      .phase_rst_i (phase_rst),
      .load_i      (xfer),
      .shadow_i    (shadow_fwd),
      .pending_o   (pending[k]),
      .sin_sgn_o   (sin_sgn[k]),
      .sin_nz_o    (sin_nz[k]),
      .cos_sgn_o   (cos_sgn[k]),
      .cos_nz_o    (cos_nz[k]),
      .wrap_o      (wrap[k])
    );
  end

  assign bus.sin_sgn = sin_sgn;
  assign bus.sin_nz  = sin_nz;
  assign bus.cos_sgn = cos_sgn;
  assign bus.cos_nz  = cos_nz;
  assign bus.wrap    = wrap;

endmodule

// File: tb/tb_lo_bank.sv
// Directed bench for lo_bank (N_CH=4, PH_W=6): expected values follow from the
// cycle count m since the last phase alignment.
module tb_lo_bank;

  logic clk = 1'b0;
  logic rstb;
  logic en;
  logic phase_rst;
  int   n_vec = 0;
  int   n_err = 0;

  lo_bank_if #(.N_CH(4), .DZ_W(5)) bus ();

  lo_bank #(
    .N_CH   (4),
    .PH_W   (6),
    .DZ_W   (5),
    .DZ_RST (5'd0)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .phase_rst (phase_rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic align();
    phase_rst = 1'b1;
    step();
    phase_rst = 1'b0;
  endtask

  task automatic test_reset();
    rstb = 1'b0; en = 1'b0; phase_rst = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_dz = 5'd0;
    step(); step();
    n_vec++;
    if ({bus.sin_sgn, bus.sin_nz, bus.cos_sgn, bus.cos_nz, bus.wrap} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 00000",
               {bus.sin_sgn, bus.sin_nz, bus.cos_sgn, bus.cos_nz, bus.wrap});
    end
    n_vec++;
    if (bus.cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b want 1", bus.cfg_ready);
    end
  endtask

  task automatic test_square();
    int p;
    rstb = 1'b1; en = 1'b1;
    for (int m = 1; m <= 130; m++) begin
      step();
      p = (m - 1) % 64;
      n_vec++;
      if (bus.sin_sgn[0] !== (p >= 32)) begin
        n_err++; $display("FAIL square_sin_sgn m=%0d: got %b want %b", m, bus.sin_sgn[0], p >= 32);
      end
      n_vec++;
      if (bus.cos_sgn[0] !== (((p + 16) % 64) >= 32)) begin
        n_err++; $display("FAIL square_cos_sgn m=%0d: got %b", m, bus.cos_sgn[0]);
      end
      n_vec++;
      if ({bus.sin_nz, bus.cos_nz} !== 8'hFF) begin
        n_err++; $display("FAIL square_nz m=%0d: got %h want ff", m, {bus.sin_nz, bus.cos_nz});
      end
      n_vec++;
      if (bus.wrap[0] !== ((m % 64) == 0)) begin
        n_err++; $display("FAIL square_wrap0 m=%0d: got %b want %b", m, bus.wrap[0], (m % 64) == 0);
      end
    end
  endtask

  task automatic test_deadzone();
    int  p;
    int  pc;
    logic e;
    bus.cfg_valid = 1'b1; bus.cfg_dz = 5'd4;
    step();
    bus.cfg_valid = 1'b0;
    n_vec++;
    if (bus.cfg_ready !== 1'b0) begin
      n_err++; $display("FAIL dz_ready_drop: got %b want 0", bus.cfg_ready);
    end
    align();
    n_vec++;
    if (bus.cfg_ready !== 1'b1 || bus.wrap !== 4'h0) begin
      n_err++; $display("FAIL dz_after_prst: ready=%b wrap=%h want 1/0", bus.cfg_ready, bus.wrap);
    end
    for (int m = 1; m <= 64; m++) begin
      step();
      p  = m - 1;
      pc = (p + 16) % 64;
      e  = !((p <= 3) || (p >= 28 && p <= 35) || (p >= 60));
      n_vec++;
      if (bus.sin_nz[0] !== e) begin
        n_err++; $display("FAIL dz4_sin_nz ph=%0d: got %b want %b", p, bus.sin_nz[0], e);
      end
      e = !((pc <= 3) || (pc >= 28 && pc <= 35) || (pc >= 60));
      n_vec++;
      if (bus.cos_nz[0] !== e) begin
        n_err++; $display("FAIL dz4_cos_nz ph=%0d: got %b want %b", p, bus.cos_nz[0], e);
      end
    end
  endtask

  task automatic test_rates();
    logic [3:0] e;
    align();
    for (int m = 1; m <= 1024; m++) begin
      step();
      for (int k = 0; k < 4; k++) e[k] = ((m % (64 << k)) == 0);
      n_vec++;
      if (bus.wrap !== e) begin
        n_err++; $display("FAIL rates_wrap m=%0d: got %b want %b", m, bus.wrap, e);
      end
    end
  endtask

  task automatic test_staged_update();
    logic e;
    align();
    for (int m = 1; m <= 600; m++) begin
      if (m == 11)  begin bus.cfg_valid = 1'b1; bus.cfg_dz = 5'd8; end
      if (m == 12)  bus.cfg_valid = 1'b0;
      if (m == 100) begin bus.cfg_valid = 1'b1; bus.cfg_dz = 5'd2; end
      if (m == 101) bus.cfg_valid = 1'b0;
      step();
      e = !(m >= 11 && m < 512);
      n_vec++;
      if (bus.cfg_ready !== e) begin
        n_err++; $display("FAIL staged_ready m=%0d: got %b want %b", m, bus.cfg_ready, e);
      end
      if (m == 6 || m == 70 || m == 580) begin
        e = (m == 6);
        n_vec++;
        if (bus.sin_nz[0] !== e) begin
          n_err++; $display("FAIL staged_ch0_nz m=%0d: got %b want %b", m, bus.sin_nz[0], e);
        end
      end
      if (m == 44 || m == 300 || m == 556) begin
        e = (m != 556);
        n_vec++;
        if (bus.sin_nz[3] !== e) begin
          n_err++; $display("FAIL staged_ch3_nz m=%0d: got %b want %b", m, bus.sin_nz[3], e);
        end
      end
    end
  endtask

  task automatic test_clamp();
    logic e;
    bus.cfg_valid = 1'b1; bus.cfg_dz = 5'd20;
    align();
    bus.cfg_valid = 1'b0;
    n_vec++;
    if (bus.cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL clamp_ready_prst: got %b want 1", bus.cfg_ready);
    end
    for (int m = 1; m <= 520; m++) begin
      if (m == 64) begin bus.cfg_valid = 1'b1; bus.cfg_dz = 5'd0; end
      if (m == 65) bus.cfg_valid = 1'b0;
      step();
      if (m <= 64) begin
        n_vec++;
        if ({bus.sin_nz, bus.cos_nz} !== 8'h00) begin
          n_err++; $display("FAIL clamp_nz m=%0d: got %h want 00", m, {bus.sin_nz, bus.cos_nz});
        end
      end
      if (m == 70 || m == 134) begin
        e = (m == 134);
        n_vec++;
        if (bus.sin_nz[0] !== e) begin
          n_err++; $display("FAIL wrap_xfer_ch0_nz m=%0d: got %b want %b", m, bus.sin_nz[0], e);
        end
      end
      if (m == 65 || m == 130 || m == 512) begin
        e = (m == 512);
        n_vec++;
        if (bus.cfg_ready !== e) begin
          n_err++; $display("FAIL clamp_ready m=%0d: got %b want %b", m, bus.cfg_ready, e);
        end
      end
      if (m == 520) begin
        n_vec++;
        if ({bus.sin_nz, bus.cos_nz} !== 8'hFF) begin
          n_err++; $display("FAIL dz0_applied_nz: got %h want ff", {bus.sin_nz, bus.cos_nz});
        end
      end
    end
  endtask

  task automatic test_hold_reset();
    logic e;
    align();
    for (int m = 1; m <= 20; m++) step();
    en = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 30) begin bus.cfg_valid = 1'b1; bus.cfg_dz = 5'd4; end
      if (i == 31) bus.cfg_valid = 1'b0;
      step();
      n_vec++;
      if ({bus.sin_sgn, bus.sin_nz, bus.cos_sgn, bus.cos_nz, bus.wrap} !== 20'h0F1F0) begin
        n_err++;
        $display("FAIL hold_outputs i=%0d: got %h want 0f1f0", i,
                 {bus.sin_sgn, bus.sin_nz, bus.cos_sgn, bus.cos_nz, bus.wrap});
      end
      e = (i < 30);
      n_vec++;
      if (bus.cfg_ready !== e) begin
        n_err++; $display("FAIL hold_ready i=%0d: got %b want %b", i, bus.cfg_ready, e);
      end
    end
    rstb = 1'b0; en = 1'b1;
    step();
    n_vec++;
    if ({bus.sin_sgn, bus.sin_nz, bus.cos_sgn, bus.cos_nz, bus.wrap, bus.cfg_ready} !== 21'h1) begin
      n_err++;
      $display("FAIL midupdate_reset: got %h want 000001",
               {bus.sin_sgn, bus.sin_nz, bus.cos_sgn, bus.cos_nz, bus.wrap, bus.cfg_ready});
    end
    rstb = 1'b1;
    for (int m = 1; m <= 70; m++) begin
      step();
      n_vec++;
      if (bus.cfg_ready !== 1'b1) begin
        n_err++; $display("FAIL post_reset_ready m=%0d: got %b want 1", m, bus.cfg_ready);
      end
      if (m <= 4 || m == 66) begin
        n_vec++;
        if (bus.sin_nz !== 4'hF) begin
          n_err++; $display("FAIL post_reset_dz m=%0d: got %h want f", m, bus.sin_nz);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_deadzone();
    test_rates();
    test_staged_update();
    test_clamp();
    test_hold_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lo_bank.md
Name: lo_bank

Overview:
- Parametrised multi-channel quadrature local-oscillator bank for the cochlea filter-bank mixers; next generation of the single-core LO.
- One internal prescaler feeds N_CH octave-spaced channels. Channel k advances at f_clk/2^k.
- Each channel produces ternary sin/cos outputs: a sign bit plus a non-zero flag, from a 2^PH_W-step phase counter.
- A programmable dead-zone width shapes the waveform around each zero crossing. Updates are glitch-free (applied at phase wrap) through a valid/ready config port.

Parameters:
- N_CH, 4, number of octave-spaced channels (>=1).
- PH_W, 6, phase counter width; steps per period P=2^PH_W; half H=P/2; quarter Q=P/4 (PH_W>=3).
- DZ_W, PH_W-1, width of dead-zone config field.
- DZ_RST, 0, dead-zone value loaded at reset.

Ports:
- clk, in, 1, system clock.
- rstb, in, 1, synchronous active-low reset.
- en, in, 1, global advance enable; when 0, prescaler and phases hold.
- phase_rst, in, 1, synchronous phase realignment pulse.
- cfg_valid, in, 1, new dead-zone request.
- cfg_dz, in, DZ_W, requested dead-zone width (samples per side of each crossing).
- cfg_ready, out, 1, high when no config update is pending.
- sin_sgn, out, N_CH, per-channel sin sign (0 = positive).
- sin_nz, out, N_CH, per-channel sin non-zero flag.
- cos_sgn, out, N_CH, per-channel cos sign.
- cos_nz, out, N_CH, per-channel cos non-zero flag.
- wrap, out, N_CH, one-cycle pulse when a channel's phase wraps.

Behaviour:
- Prescaler: binary, width max(N_CH-1,1). Increments by 1 on each cycle with en=1 and wraps naturally.
- Channel tick: tick[0]=en. For k>0, tick[k]=en & (pre[k-1:0] all ones).
- Phase: ph[k] (PH_W bits) increments mod P on tick[k].
- Decode for phase p: q = p mod H.
  - nz = 0 iff q < dz or q > H-1-dz.
  - sgn = p[PH_W-1].
  - sin uses p = ph[k]. cos uses p = (ph[k]+Q) mod P, so cos leads sin by a quarter period.
  - dz values above Q clamp to Q, which forces nz=0 everywhere. dz=0 gives a plain square wave with nz=1 everywhere.
- Outputs are registered: they reflect the phase and active dz of the previous cycle (latency 1). No combinational path from inputs to outputs.
- wrap[k] is registered and aligned with the outputs. It is high for the one cycle following the tick that moved ph[k] from P-1 to 0.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - On transfer: cfg_dz goes to a shadow register, every channel's pending bit is set, and cfg_ready drops the next cycle.
  - Channel k copies shadow into its dz_act[k] on the tick where ph[k] goes P-1 -> 0, and clears its pending bit.
  - cfg_ready returns high the cycle after the last pending bit clears.
  - cfg_valid while cfg_ready=0 is ignored; no queueing.
- Simultaneous events:
  - A channel wrapping in the same cycle as a transfer does not apply the new value; it applies at its next wrap.
  - phase_rst=1: next cycle prescaler=0 and all ph=0. All pending shadows apply immediately and cfg_ready=1.
  - phase_rst together with an accepted transfer: the new value applies to all channels at the reset. phase_rst overrides en.
  - No wrap pulse is generated by phase_rst.
- Reset (rstb=0, sampled on clk):
  - pre=0, ph=0, dz_act=DZ_RST, shadow=DZ_RST, pending=0.
  - All outputs 0 except cfg_ready=1.
  - Reset mid-update discards the pending config.
- en=0: phases and outputs hold; config still accepted; no wraps occur, so pending stays pending.

Decomposition:
- Package lo_pkg: derived constants P, H, Q; a dz clamp function; a ternary decode function (phase, dz -> sgn, nz) shared by the sin and cos paths.
- Sub-module lo_channel, one per channel: phase counter, dz_act/pending, sin/cos decode, output and wrap registers. Inputs: tick, phase_rst, load, shadow.
- Top level lo_bank: prescaler, tick generation, config handshake, generate loop over lo_channel.

Test Plan (N_CH=4, PH_W=6: P=64, H=32, Q=16):
- Reset, en=1, dz=0 -> ch0 sin_sgn low 32 cycles then high 32; sin_nz=1 throughout; cos_sgn edges 16 cycles before sin_sgn edges; wrap[0] every 64 cycles.
- cfg_dz=4 accepted, then phase_rst -> ch0 sin_nz=0 exactly at ph in {0..3, 28..35, 60..63}; nz=1 elsewhere; cfg_ready=1 the cycle after phase_rst.
- Channel rates with en=1 -> wrap[1] period 128, wrap[2] 256, wrap[3] 512 cycles; all wraps coincide every 512 cycles.
- cfg_dz=8 accepted at ch0 ph=10 -> ch0 shape changes only after the next wrap[0]; ch3 changes after wrap[3]; cfg_ready stays low until ch3 applies; a second cfg_valid in this window is ignored.
- cfg_dz=20 -> clamps to 16; all sin_nz and cos_nz = 0 after apply.
- en=0 for 100 cycles mid-period -> all outputs frozen and no wrap; rstb=0 for one cycle mid-update -> outputs 0, cfg_ready=1, dz back to DZ_RST.
